// File: rtl/jtkcpu_intctl.sv
// Interrupt controller for the jtkcpu control path: NMI plus NCH maskable channels,
// fixed-priority commit at instruction boundaries, held until microcode acknowledge.
//
//   state | meaning
//   IDLE  | no committed request; arbitrate when int_en is high
//   SERVE | winner committed on int_* outputs, frozen until int_ack
module jtkcpu_intctl #(
    parameter int              NCH         = 2,
    parameter int              SYNC_STAGES = 2,
    parameter logic [NCH-1:0]  EDGE_MASK   = {NCH{1'b0}},
    parameter logic [NCH-1:0]  FAST_MASK   = {{(NCH-1){1'b0}}, 1'b1},
    parameter logic [15:0]     VEC_NMI     = 16'hFFFC,
    parameter logic [15:0]     VEC_BASE    = 16'hFFF6,
    parameter logic [15:0]     VEC_STEP    = 16'd2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            nmi_n,
    input  logic [NCH-1:0]  irq_n,
    input  logic [NCH-1:0]  int_mask,
    input  logic            nmi_arm,
    input  logic            int_en,
    input  logic            int_ack,
    input  logic            sync_wait,
    output logic            int_req,
    output logic            int_nmi,
    output logic [NCH-1:0]  int_ch,
    output logic            int_fast,
    output logic [15:0]     int_vec,
    output logic            wake,
    output logic            nmi_armed
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t          state_q, state_d;

    // Bit NCH carries nmi_n, bits NCH-1:0 carry irq_n.
    logic [NCH:0]    sync_q [SYNC_STAGES];
    logic [NCH:0]    prev_q;
    logic [NCH:0]    in_sync;
    logic [NCH:0]    fall;

    logic [NCH-1:0]  edge_q, edge_d;
    logic [NCH-1:0]  pend;
    logic [NCH-1:0]  elig;
    logic            nmi_pend_q, nmi_pend_d;
    logic            nmi_armed_q, nmi_armed_d;
    logic            wake_q, wake_d;

    logic            int_nmi_q, int_nmi_d;
    logic [NCH-1:0]  int_ch_q, int_ch_d;
    logic            int_fast_q, int_fast_d;
    logic [15:0]     int_vec_q, int_vec_d;

    logic            win_found;
    logic [NCH-1:0]  win_ch;
    logic            win_fast;
    logic [15:0]     win_vec;
    logic            ack_go;

    assign in_sync = sync_q[SYNC_STAGES-1];
    assign fall    = prev_q & ~in_sync;
    assign pend    = (EDGE_MASK & edge_q) | (~EDGE_MASK & ~in_sync[NCH-1:0]);
    assign elig    = pend & ~int_mask;
    assign ack_go  = cen & int_ack & (state_q == SERVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
            prev_q <= '1;
        end else if (cen) begin
            sync_q[0] <= {nmi_n, irq_n};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= in_sync;
        end
    end

    // Clear of the served latch is applied first so a coincident new edge wins.
    always_comb begin
        nmi_armed_d = nmi_armed_q | (cen & nmi_arm);
        nmi_pend_d  = nmi_pend_q;
        edge_d      = edge_q;
        if (ack_go) begin
            if (int_nmi_q) begin
                nmi_pend_d = 1'b0;
            end else begin
                edge_d = edge_q & ~int_ch_q;
            end
        end
        if (cen) begin
            if (fall[NCH] && nmi_armed_q) begin
                nmi_pend_d = 1'b1;
            end
            edge_d = edge_d | (fall[NCH-1:0] & EDGE_MASK);
        end
        wake_d = cen ? (sync_wait & (nmi_pend_q | (|pend))) : wake_q;
    end

    always_comb begin
        win_found = nmi_pend_q;
        win_ch    = '0;
        win_fast  = 1'b0;
        win_vec   = VEC_NMI;
        if (!nmi_pend_q) begin
            for (int i = 0; i < NCH; i++) begin
                if (elig[i] && !win_found) begin
                    win_found = 1'b1;
                    win_ch[i] = 1'b1;
                    win_fast  = FAST_MASK[i];
                    win_vec   = VEC_BASE + VEC_STEP * 16'(i);
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        int_nmi_d  = int_nmi_q;
        int_ch_d   = int_ch_q;
        int_fast_d = int_fast_q;
        int_vec_d  = int_vec_q;
        if (state_q == IDLE) begin
            if (cen && int_en && win_found) begin
                state_d    = SERVE;
                int_nmi_d  = nmi_pend_q;
                int_ch_d   = win_ch;
                int_fast_d = win_fast;
                int_vec_d  = win_vec;
            end
        end else begin
            if (ack_go) begin
                state_d    = IDLE;
                int_nmi_d  = 1'b0;
                int_ch_d   = '0;
                int_fast_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            edge_q      <= '0;
            nmi_pend_q  <= 1'b0;
            nmi_armed_q <= 1'b0;
            wake_q      <= 1'b0;
            int_nmi_q   <= 1'b0;
            int_ch_q    <= '0;
            int_fast_q  <= 1'b0;
            int_vec_q   <= '0;
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            nmi_pend_q  <= nmi_pend_d;
            nmi_armed_q <= nmi_armed_d;
            wake_q      <= wake_d;
            int_nmi_q   <= int_nmi_d;
            int_ch_q    <= int_ch_d;
            int_fast_q  <= int_fast_d;
            int_vec_q   <= int_vec_d;
        end
    end

    assign int_req   = (state_q == SERVE);
    assign int_nmi   = int_nmi_q;
    assign int_ch    = int_ch_q;
    assign int_fast  = int_fast_q;
    assign int_vec   = int_vec_q;
    assign wake      = wake_q;
    assign nmi_armed = nmi_armed_q;

endmodule

// File: tb/tb_jtkcpu_intctl.sv
// Scoreboard bench for jtkcpu_intctl: NCH=2, two-stage sync, channel 0 edge, channel 1 level.
module tb_jtkcpu_intctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        nmi_n;
    logic [1:0]  irq_n;
    logic [1:0]  int_mask;
    logic        nmi_arm;
    logic        int_en;
    logic        int_ack;
    logic        sync_wait;
    logic        int_req;
    logic        int_nmi;
    logic [1:0]  int_ch;
    logic        int_fast;
    logic [15:0] int_vec;
    logic        wake;
    logic        nmi_armed;

    typedef struct packed {
        logic        req;
        logic        nmi;
        logic [1:0]  ch;
        logic        fast;
        logic [15:0] vec;
        logic        wake;
        logic        armed;
    } exp_t;

    exp_t exp_q[$];
    logic exp_armed;
    int   checks   = 0;
    int   failures = 0;

    jtkcpu_intctl #(
        .NCH         (2),
        .SYNC_STAGES (2),
        .EDGE_MASK   (2'b01),
        .FAST_MASK   (2'b01),
        .VEC_NMI     (16'hFFFC),
        .VEC_BASE    (16'hFFF6),
        .VEC_STEP    (16'd2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .int_mask  (int_mask),
        .nmi_arm   (nmi_arm),
        .int_en    (int_en),
        .int_ack   (int_ack),
        .sync_wait (sync_wait),
        .int_req   (int_req),
        .int_nmi   (int_nmi),
        .int_ch    (int_ch),
        .int_fast  (int_fast),
        .int_vec   (int_vec),
        .wake      (wake),
        .nmi_armed (nmi_armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic req, input logic nmi, input logic [1:0] ch,
                            input logic fast, input logic [15:0] vec, input logic wk);
        exp_t e;
        e.req   = req;
        e.nmi   = nmi;
        e.ch    = ch;
        e.fast  = fast;
        e.vec   = vec;
        e.wake  = wk;
        e.armed = exp_armed;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk({tag, "_req"},   32'(int_req),   32'(e.req));
        chk({tag, "_nmi"},   32'(int_nmi),   32'(e.nmi));
        chk({tag, "_ch"},    32'(int_ch),    32'(e.ch));
        chk({tag, "_fast"},  32'(int_fast),  32'(e.fast));
        chk({tag, "_vec"},   32'(int_vec),   32'(e.vec));
        chk({tag, "_wake"},  32'(wake),      32'(e.wake));
        chk({tag, "_armed"}, 32'(nmi_armed), 32'(e.armed));
    endtask

    task automatic ack_and_check(input string tag, input logic [15:0] vec);
        int_en  = 1'b0;
        int_ack = 1'b1;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, vec, 1'b0);
        tick(1);
        int_ack = 1'b0;
        sb_check(tag);
    endtask

    initial begin
        rst       = 1'b1;
        cen       = 1'b1;
        nmi_n     = 1'b1;
        irq_n     = 2'b11;
        int_mask  = 2'b00;
        nmi_arm   = 1'b0;
        int_en    = 1'b0;
        int_ack   = 1'b0;
        sync_wait = 1'b0;
        exp_armed = 1'b0;

        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0);
        tick(2);
        sb_check("reset");
        rst = 1'b0;

        // Edge channel 0: pending after SYNC_STAGES+1, committed one cycle later.
        irq_n  = 2'b10;
        int_en = 1'b1;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0);
        tick(3);
        sb_check("e0_lat3");
        push_exp(1'b1, 1'b0, 2'b01, 1'b1, 16'hFFF6, 1'b0);
        tick(1);
        sb_check("e0_serve");
        ack_and_check("e0_ack", 16'hFFF6);

        // Level channel 1 with channel 0 masked; frozen while serving.
        irq_n    = 2'b00;
        int_mask = 2'b01;
        int_en   = 1'b1;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'hFFF6, 1'b0);
        tick(2);
        sb_check("l1_lat2");
        push_exp(1'b1, 1'b0, 2'b10, 1'b0, 16'hFFF8, 1'b0);
        tick(1);
        sb_check("l1_serve");
        int_mask = 2'b00;
        push_exp(1'b1, 1'b0, 2'b10, 1'b0, 16'hFFF8, 1'b0);
        tick(2);
        sb_check("l1_frozen");
        irq_n = 2'b11;
        ack_and_check("l1_ack", 16'hFFF8);
        tick(3);

        // NMI edge while disarmed is discarded.
        nmi_n  = 1'b0;
        int_en = 1'b1;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'hFFF8, 1'b0);
        tick(4);
        sb_check("nmi_disarmed");
        nmi_n  = 1'b1;
        int_en = 1'b0;
        tick(3);
        nmi_arm   = 1'b1;
        exp_armed = 1'b1;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'hFFF8, 1'b0);
        tick(1);
        nmi_arm = 1'b0;
        sb_check("arm");

        // NMI, ch0 and ch1 all pending: served in priority order.
        nmi_n = 1'b0;
        irq_n = 2'b00;
        tick(3);
        int_en = 1'b1;
        push_exp(1'b1, 1'b1, 2'b00, 1'b0, 16'hFFFC, 1'b0);
        tick(1);
        int_en = 1'b0;
        sb_check("nmi_serve");
        ack_and_check("nmi_ack", 16'hFFFC);
        int_en = 1'b1;
        push_exp(1'b1, 1'b0, 2'b01, 1'b1, 16'hFFF6, 1'b0);
        tick(1);
        int_en = 1'b0;
        sb_check("prio_ch0");
        ack_and_check("prio_ch0_ack", 16'hFFF6);
        int_en = 1'b1;
        push_exp(1'b1, 1'b0, 2'b10, 1'b0, 16'hFFF8, 1'b0);
        tick(1);
        int_en = 1'b0;
        sb_check("prio_ch1");
        ack_and_check("prio_ch1_ack", 16'hFFF8);

        // One-cycle pulse on edge channel 0 is latched.
        irq_n    = 2'b01;
        int_mask = 2'b10;
        tick(3);
        irq_n = 2'b00;
        tick(1);
        irq_n = 2'b01;
        tick(2);
        int_en = 1'b1;
        push_exp(1'b1, 1'b0, 2'b01, 1'b1, 16'hFFF6, 1'b0);
        tick(1);
        int_en = 1'b0;
        sb_check("pulse_serve");

        // New edge landing on the ack cycle keeps the latch set.
        irq_n = 2'b00;
        tick(1);
        irq_n   = 2'b01;
        tick(1);
        int_ack = 1'b1;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'hFFF6, 1'b0);
        tick(1);
        int_ack = 1'b0;
        sb_check("ack_coinc");
        int_en = 1'b1;
        push_exp(1'b1, 1'b0, 2'b01, 1'b1, 16'hFFF6, 1'b0);
        tick(1);
        int_en = 1'b0;
        sb_check("set_beats_clr");
        ack_and_check("set_beats_clr_ack", 16'hFFF6);

        // cen=0 freezes arbitration.
        int_mask = 2'b00;
        cen      = 1'b0;
        int_en   = 1'b1;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'hFFF6, 1'b0);
        tick(2);
        sb_check("cen_hold");
        cen = 1'b1;
        push_exp(1'b1, 1'b0, 2'b10, 1'b0, 16'hFFF8, 1'b0);
        tick(1);
        int_en = 1'b0;
        sb_check("cen_resume");
        ack_and_check("cen_ack", 16'hFFF8);

        // Wake from masked pending channel.
        irq_n = 2'b11;
        tick(3);
        int_mask  = 2'b11;
        sync_wait = 1'b1;
        int_en    = 1'b1;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'hFFF8, 1'b0);
        tick(1);
        sb_check("wake_idle");
        irq_n = 2'b01;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'hFFF8, 1'b0);
        tick(2);
        sb_check("wake_lat2");
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'hFFF8, 1'b1);
        tick(1);
        sb_check("wake_lat3");
        sync_wait = 1'b0;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'hFFF8, 1'b0);
        tick(1);
        sb_check("wake_drop");

        // Reset in SERVE abandons the request and disarms NMI.
        int_mask = 2'b00;
        push_exp(1'b1, 1'b0, 2'b10, 1'b0, 16'hFFF8, 1'b0);
        tick(1);
        sb_check("pre_rst");
        rst       = 1'b1;
        exp_armed = 1'b0;
        #1;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0);
        sb_check("rst_serve");
        tick(1);
        rst    = 1'b0;
        int_en = 1'b0;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0);
        tick(2);
        sb_check("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
